mem_port_arbiter: RTL and testbench

Shares the single synchronous data-memory port between the CPU control/datapath and the host loader/debug port. Each requester uses a req/gnt handshake. The arbiter drives the RAM port and routes 1-cycle-latency read data back to the owner of the read. It sits between the CPU memory interface (MemEn/MemWen) and the data RAM. It enables program load and inspection while the CPU runs or is halted.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_rr_lock.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 71 +++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory port: response-owner encoding,
// default bus widths and the RAM read latency.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2
  } owner_e;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU request port, the host loader port and the RAM port.
// slave is the arbiter side, master is the environment (CPU, host, RAM).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_halted;

  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halted,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_halted,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_lock.sv
// Two-way grant logic: halt and lock priority over a round-robin fallback,
// with the rr_last and lock_cnt state registers.
module rr_lock_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic host_req,
  input  logic cpu_halted,
  input  logic host_lock,
  output logic cpu_gnt,
  output logic host_gnt
);

  localparam int                CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(MAX_LOCK);

  owner_e           rr_last, rr_next;
  logic [CNT_W-1:0] lock_cnt, cnt_next;
  logic             lock_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last  <= HOST;
      lock_cnt <= '0;
    end else begin
      rr_last  <= rr_next;
      lock_cnt <= cnt_next;
    end
  end

  assign lock_ok = host_lock && (lock_cnt < LOCK_MAX);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    rr_next  = rr_last;
    cnt_next = lock_cnt;

    // Grants are suppressed while reset is held so the RAM port stays idle.
    if (!reset) begin
      if (cpu_req && !host_req) begin
        cpu_gnt = 1'b1;
      end else if (host_req && !cpu_req) begin
        host_gnt = 1'b1;
      end else if (cpu_req && host_req) begin
        if (cpu_halted || lock_ok) host_gnt = 1'b1;
        else if (rr_last == HOST)  cpu_gnt  = 1'b1;
        else                       host_gnt = 1'b1;
      end
    end

    if (cpu_gnt)       rr_next = CPU;
    else if (host_gnt) rr_next = HOST;

    // Lock budget only accrues while the CPU is actually being kept waiting.
    if (cpu_gnt || !host_lock || !cpu_req) cnt_next = '0;
    else if (host_gnt && (lock_cnt < LOCK_MAX)) cnt_next = lock_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous data RAM between the CPU and the host loader port;
// muxes the granted request onto the RAM and steers read data back.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  logic              cpu_gnt, host_gnt;
  owner_e            rsp_owner;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  rr_lock_arbiter #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (bus.cpu_req),
    .host_req   (bus.host_req),
    .cpu_halted (bus.cpu_halted),
    .host_lock  (bus.host_lock),
    .cpu_gnt    (cpu_gnt),
    .host_gnt   (host_gnt)
  );

  assign bus.cpu_gnt  = cpu_gnt;
  assign bus.host_gnt = host_gnt;
  assign bus.mem_en   = cpu_gnt | host_gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  // rsp_owner marks the cycle in which mem_rdata belongs to a requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_owner    <= NONE;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (bus.mem_en && !bus.mem_we) rsp_owner <= cpu_gnt ? CPU : HOST;
      else                           rsp_owner <= NONE;
      if (rsp_owner == CPU)  cpu_rdata_q  <= bus.mem_rdata;
      if (rsp_owner == HOST) host_rdata_q <= bus.mem_rdata;
    end
  end

  // Response data is live in the rvalid cycle and held afterwards.
  assign bus.cpu_rvalid  = (rsp_owner == CPU);
  assign bus.host_rvalid = (rsp_owner == HOST);
  assign bus.cpu_rdata   = bus.cpu_rvalid  ? bus.mem_rdata : cpu_rdata_q;
  assign bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized stimulus for mem_port_arbiter, checked every cycle
// against a behavioural model of the arbitration rules and a shadow memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
    if (a == 10'h010) return 32'hDEADBEEF;
    return {22'h0, a} ^ 32'hA5A5_0000;
  endfunction

  // Environment RAM with one-cycle read latency.
  bit [31:0] ram [DEPTH];
  bit        wr  [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= wr[bus.mem_addr] ? ram[bus.mem_addr] : init_word(bus.mem_addr);
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_mem [DEPTH];
  int          m_last, m_lock, m_rsp, m_w;
  logic [31:0] m_rsp_data, m_cpu_rd, m_host_rd;
  logic        obs_cpu_gnt, obs_host_gnt;
  string       phase;

  task automatic model_reset();
    m_last = 2; m_lock = 0; m_rsp = 0; m_w = 0;
    m_rsp_data = '0; m_cpu_rd = '0; m_host_rd = '0;
  endtask

  function automatic int winner();
    bit c = bus.cpu_req, h = bus.host_req;
    if (c && !h) return 1;
    if (h && !c) return 2;
    if (!c && !h) return 0;
    if (bus.cpu_halted) return 2;
    if (bus.host_lock && m_lock < MAX_LOCK) return 2;
    return (m_last == 1) ? 2 : 1;
  endfunction

  // Inputs are set before calling; checks at the falling edge, then advances.
  task automatic step();
    int w;
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    @(negedge clk);
    w  = winner();
    we = (w == 1) ? bus.cpu_we   : (w == 2) ? bus.host_we   : 1'b0;
    a  = (w == 1) ? bus.cpu_addr : (w == 2) ? bus.host_addr : '0;
    wd = (w == 1) ? bus.cpu_wdata: (w == 2) ? bus.host_wdata: '0;
    obs_cpu_gnt  = bus.cpu_gnt;
    obs_host_gnt = bus.host_gnt;
    check({phase, ".cpu_gnt"},     bus.cpu_gnt,     w == 1);
    check({phase, ".host_gnt"},    bus.host_gnt,    w == 2);
    check({phase, ".mem_en"},      bus.mem_en,      w != 0);
    check({phase, ".mem_we"},      bus.mem_we,      we);
    check({phase, ".mem_addr"},    bus.mem_addr,    a);
    check({phase, ".mem_wdata"},   bus.mem_wdata,   wd);
    check({phase, ".cpu_rvalid"},  bus.cpu_rvalid,  m_rsp == 1);
    check({phase, ".host_rvalid"}, bus.host_rvalid, m_rsp == 2);
    check({phase, ".cpu_rdata"},   bus.cpu_rdata,   (m_rsp == 1) ? m_rsp_data : m_cpu_rd);
    check({phase, ".host_rdata"},  bus.host_rdata,  (m_rsp == 2) ? m_rsp_data : m_host_rd);

    if (m_rsp == 1) m_cpu_rd  = m_rsp_data;
    if (m_rsp == 2) m_host_rd = m_rsp_data;
    m_rsp = 0;
    if (w != 0) begin
      if (we) m_mem[a] = wd;
      else begin
        m_rsp      = w;
        m_rsp_data = m_mem[a];
      end
      m_last = w;
    end
    if (w == 1 || !bus.host_lock || !bus.cpu_req) m_lock = 0;
    else if (w == 2 && m_lock < MAX_LOCK) m_lock++;
    m_w = w;
    @(posedge clk); #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input int addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = ADDR_W'(addr); bus.cpu_wdata = wd;
  endtask

  task automatic set_host(input bit req, input bit we, input int addr, input logic [31:0] wd);
    bus.host_req = req; bus.host_we = we; bus.host_addr = ADDR_W'(addr); bus.host_wdata = wd;
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
  endfunction

  // Requesters hold a request until granted, occasionally dropping it.
  task automatic drive_random();
    if (!bus.cpu_req || m_w == 1 || $urandom_range(0, 15) == 0)
      set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
    if (!bus.host_req || m_w == 2 || $urandom_range(0, 15) == 0)
      set_host($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
    if ($urandom_range(0, 7) == 0) bus.host_lock  = $urandom_range(0, 1) == 1;
    if ($urandom_range(0, 15) == 0) bus.cpu_halted = $urandom_range(0, 3) == 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cpu_gnt"},     bus.cpu_gnt,     1'b0);
    check({tag, ".host_gnt"},    bus.host_gnt,    1'b0);
    check({tag, ".mem_en"},      bus.mem_en,      1'b0);
    check({tag, ".mem_we"},      bus.mem_we,      1'b0);
    check({tag, ".mem_addr"},    bus.mem_addr,    '0);
    check({tag, ".cpu_rvalid"},  bus.cpu_rvalid,  1'b0);
    check({tag, ".host_rvalid"}, bus.host_rvalid, 1'b0);
    check({tag, ".cpu_rdata"},   bus.cpu_rdata,   '0);
    check({tag, ".host_rdata"},  bus.host_rdata,  '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(ADDR_W'(i));
    model_reset();
    phase = "reset";
    reset = 1'b1;
    bus.mem_rdata = '0;
    bus.cpu_halted = 1'b0;
    bus.host_lock  = 1'b0;
    set_cpu(1, 0, 16, 0);
    set_host(1, 0, 0, 0);
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;

    // CPU read of 0x010 alone, then an idle cycle for the response.
    set_host(0, 0, 0, 0);
    reset = 1'b0;
    phase = "cpu_read";
    set_cpu(1, 0, 16, 0);
    step();
    set_cpu(0, 0, 0, 0);
    step();
    check("cpu_read.held", bus.cpu_rdata, 32'hDEADBEEF);

    // Contended, unlocked, running CPU: strict alternation.
    phase = "alternate";
    set_cpu(1, 0, 1, 0);
    set_host(1, 0, 2, 0);
    repeat (4) step();

    // Locked host write burst against a waiting CPU.
    phase = "lock";
    bus.host_lock = 1'b1;
    set_cpu(1, 0, 3, 0);
    for (int i = 0; i < 10; i++) begin
      set_host(1, 1, 32 + i, 32'h1000 + i);
      step();
      check($sformatf("lock.host_gnt%0d", i), obs_host_gnt, (i != 8));
    end
    bus.host_lock = 1'b0;

    // Halted CPU: host owns every contended cycle.
    phase = "halted";
    bus.cpu_halted = 1'b1;
    set_cpu(1, 0, 4, 0);
    set_host(1, 0, 5, 0);
    repeat (5) step();
    bus.cpu_halted = 1'b0;

    // Host write then read of the top address.
    phase = "top_addr";
    set_cpu(0, 0, 0, 0);
    set_host(1, 1, DEPTH - 1, 32'h12345678);
    step();
    set_host(1, 0, DEPTH - 1, 0);
    step();
    set_host(0, 0, 0, 0);
    step();
    check("top_addr.held", bus.host_rdata, 32'h12345678);

    // Reset asserted while a CPU read response is pending.
    phase = "mid_reset";
    set_cpu(1, 0, 16, 0);
    step();
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    set_cpu(0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Randomized traffic.
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
